// File: rtl/ecall_uart_tx.sv
// ecall_uart_tx: buffers 32-bit CPU ecall words in a small FIFO and streams each
// word out as four 8N1 UART bytes, least-significant byte first.
`default_nettype none

module ecall_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_ecall_ready,
   input  logic [31:0]                   i_ecall_data,
   output logic                          o_uart_tx,
   output logic                          o_busy,
   output logic                          o_full,
   output logic                          o_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CLK_W = $clog2(CLKS_PER_BIT);
   localparam logic [CLK_W-1:0] LAST_CLK  = CLK_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [31:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             full;
   logic             push;
   logic             pop;
   logic             drop;

   state_t           state;
   state_t           state_n;
   logic [CLK_W-1:0] clk_cnt;
   logic [CLK_W-1:0] clk_cnt_n;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_n;
   logic [1:0]       byte_idx;
   logic [1:0]       byte_idx_n;
   logic [31:0]      shreg;
   logic [31:0]      shreg_n;
   logic             tx;
   logic             tx_n;
   logic             last_clk;

   // A pop in IDLE frees a slot at the same edge, so a full FIFO still accepts then.
   assign full = (count == DEPTH_CNT);
   assign pop  = (state == IDLE) && (count != '0);
   assign push = i_ecall_ready && (!full || pop);
   assign drop = i_ecall_ready && full && !pop;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (drop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_ecall_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= IDLE;
         clk_cnt  <= '0;
         bit_idx  <= '0;
         byte_idx <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         clk_cnt  <= clk_cnt_n;
         bit_idx  <= bit_idx_n;
         byte_idx <= byte_idx_n;
         shreg    <= shreg_n;
         tx       <= tx_n;
      end
   end

   always_comb begin
      state_n    = state;
      clk_cnt_n  = clk_cnt;
      bit_idx_n  = bit_idx;
      byte_idx_n = byte_idx;
      shreg_n    = shreg;
      last_clk   = (clk_cnt == LAST_CLK);

      case (state)
         IDLE: begin
            if (pop) begin
               state_n    = START;
               shreg_n    = mem[rd_ptr];
               clk_cnt_n  = '0;
               bit_idx_n  = '0;
               byte_idx_n = '0;
            end
         end
         START: begin
            if (last_clk) begin
               state_n   = DATA;
               clk_cnt_n = '0;
               bit_idx_n = '0;
            end else begin
               clk_cnt_n = clk_cnt + CLK_W'(1);
            end
         end
         DATA: begin
            if (last_clk) begin
               // Shifting after every data bit leaves the next byte in [7:0].
               clk_cnt_n = '0;
               shreg_n   = {1'b0, shreg[31:1]};
               if (bit_idx == 3'd7) begin
                  state_n   = STOP;
                  bit_idx_n = '0;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
               end
            end else begin
               clk_cnt_n = clk_cnt + CLK_W'(1);
            end
         end
         STOP: begin
            if (last_clk) begin
               clk_cnt_n = '0;
               bit_idx_n = '0;
               if (byte_idx != 2'd3) begin
                  byte_idx_n = byte_idx + 2'd1;
                  state_n    = START;
               end else begin
                  byte_idx_n = '0;
                  state_n    = IDLE;
               end
            end else begin
               clk_cnt_n = clk_cnt + CLK_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      // The line level is registered from the next state so it never glitches.
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shreg_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   assign o_uart_tx  = tx;
   assign o_busy     = (count != '0) || (state != IDLE);
   assign o_full     = full;
   assign o_overflow = overflow;
   assign o_count    = count;

endmodule

`default_nettype wire

// File: doc/ecall_uart_tx.md
ECALL_UART_TX -- requirements
Module: ecall_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit period (integer >= 2).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of 32-bit word entries (power of 2, >= 2).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_ecall_ready  input  1  one ecall word offered per cycle this is high; driven by the CPU ecall ready output.
REQ-006 SHALL have port i_ecall_data  input  32  ecall word, valid while i_ecall_ready=1.
REQ-007 SHALL have port o_uart_tx  output  1  serial line, 8N1, idle high, registered.
REQ-008 SHALL have port o_busy  output  1  high while FIFO non-empty or the FSM is not in IDLE.
REQ-009 SHALL have port o_full  output  1  high when FIFO count == FIFO_DEPTH.
REQ-010 SHALL have port o_overflow  output  1  sticky flag for a dropped ecall word.
REQ-011 SHALL have port o_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 SHALL push i_ecall_data into the FIFO at each rising edge where i_ecall_ready=1 and (count < FIFO_DEPTH or a pop occurs at the same edge).
REQ-013 SHALL drop the word and set o_overflow=1 when i_ecall_ready=1, count == FIFO_DEPTH and no pop occurs at that edge; o_overflow clears only on reset.
REQ-014 SHALL update count by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; read/write pointers wrap modulo FIFO_DEPTH.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 In IDLE with count > 0, SHALL pop the head word into a 32-bit shift register, clear byte index to 0 and go to START at the same edge; in IDLE with count == 0, SHALL stay in IDLE.
REQ-017 In START, SHALL drive o_uart_tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
REQ-018 In DATA, SHALL drive the 8 bits of the current byte LSB first, each for CLKS_PER_BIT cycles, then go to STOP.
REQ-019 In STOP, SHALL drive o_uart_tx=1 for CLKS_PER_BIT cycles; then if byte index < 3, SHALL increment it and go to START; otherwise SHALL go to IDLE.
REQ-020 SHALL send byte order data[7:0], [15:8], [23:16], [31:24], with no gap between bytes of one word.
REQ-021 One word frame SHALL take exactly 40*CLKS_PER_BIT cycles from the first start-bit cycle to the end of the last stop bit.
REQ-022 Consecutive words SHALL be separated by exactly one IDLE cycle with o_uart_tx=1.
REQ-023 With the FIFO empty and the FSM in IDLE, the start bit SHALL appear on o_uart_tx 2 cycles after the cycle in which i_ecall_ready is sampled high.
REQ-024 o_uart_tx SHALL be 1 in IDLE and SHALL never glitch (registered output).
REQ-025 Bit-period and bit/byte counters SHALL be sized for CLKS_PER_BIT-1, 7 and 3 respectively, and SHALL reset to 0 on every state entry.

Reset
REQ-026 When i_rst_n=0, SHALL immediately force o_uart_tx=1, FSM=IDLE, FIFO pointers and count=0, o_overflow=0, all counters=0, regardless of any frame in progress.
REQ-027 After reset, o_busy=0, o_full=0 and o_count=0; FIFO contents need not be cleared.
REQ-028 Words pushed before reset SHALL NOT be transmitted after reset release.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single ecall 0x44434241 while idle -> bytes 0x41, 0x42, 0x43, 0x44 sent 8N1 LSB first, start bit 2 cycles after the ecall, 160 frame cycles, then o_busy=0.
REQ-030 6 consecutive ecall cycles 0x1..0x6 while idle -> words 0x1..0x5 transmitted in order, 0x6 dropped, o_overflow=1, o_full=1 for the cycle after the 6th ecall.
REQ-031 FIFO full and ecall 0xA5A5A5A5 on the edge where IDLE pops -> word accepted, count stays 4, o_overflow stays 0.
REQ-032 Reset asserted mid-DATA of byte 2 with 2 words queued -> o_uart_tx=1 within the same cycle, o_count=0, o_busy=0, nothing sent after release.
REQ-033 Second ecall pushed during STOP of byte 3 of the first word -> exactly one idle-high cycle, then the start bit of the second word.
REQ-034 Ecall words 0x000000FF and 0x80000000 -> bit patterns verified at the centre of every bit period, including stop bits.
